// File: rtl/hamming_ascii_tx.sv
// rtl/hamming_ascii_tx.sv - Hamming(12,8) encoder that streams the codeword as ASCII bits into a TX FIFO
module hamming_ascii_tx #(
   parameter bit         TERM      = 1'b1,
   parameter logic [7:0] CHAR_ONE  = 8'h31,
   parameter logic [7:0] CHAR_ZERO = 8'h30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        tx_full,
   output logic        tx_wr,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic [11:0] cw_out
);

   typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [11:0] cw_reg, cw_nxt;
   logic [11:0] cw_enc;
   logic        p1, p2, p4, p8;

   // cw_enc[i] holds codeword position i+1; parity bits sit at the power-of-two positions
   always_comb begin
      p1 = in_data[0] ^ in_data[1] ^ in_data[3] ^ in_data[4] ^ in_data[6];
      p2 = in_data[0] ^ in_data[2] ^ in_data[3] ^ in_data[5] ^ in_data[6];
      p4 = in_data[1] ^ in_data[2] ^ in_data[3] ^ in_data[7];
      p8 = in_data[4] ^ in_data[5] ^ in_data[6] ^ in_data[7];
      cw_enc = {in_data[7], in_data[6], in_data[5], in_data[4], p8,
                in_data[3], in_data[2], in_data[1], p4, in_data[0], p2, p1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         cw_reg <= 12'd0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         cw_reg <= cw_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cw_nxt    = cw_reg;
      in_ready  = 1'b0;
      tx_wr     = 1'b0;
      tx_data   = 8'h00;
      case (state)
         IDLE: begin
            in_ready = ~reset;
            if (in_valid && !reset) begin
               cw_nxt    = cw_enc;
               cnt_nxt   = 4'd11;
               state_nxt = SEND;
            end
         end
         SEND: begin
            tx_data = cw_reg[cnt] ? CHAR_ONE : CHAR_ZERO;
            if (!tx_full) begin
               tx_wr = 1'b1;
               // leave on cnt==0 so the 4-bit counter never wraps
               if (cnt == 4'd0) begin
                  if (TERM) state_nxt = CR;
                  else      state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
         end
         CR: begin
            tx_data = 8'h0D;
            if (!tx_full) begin
               tx_wr     = 1'b1;
               state_nxt = LF;
            end
         end
         LF: begin
            tx_data = 8'h0A;
            if (!tx_full) begin
               tx_wr     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy   = (state != IDLE);
   assign cw_out = cw_reg;

endmodule

// File: tb/tb_hamming_ascii_tx.sv
// tb/tb_hamming_ascii_tx.sv - randomized bench for hamming_ascii_tx against a generic Hamming model
module tb_hamming_ascii_tx;

   logic        clk;
   logic        reset;
   logic [1:0]  in_valid, in_ready, tx_full, tx_wr, busy;
   logic [7:0]  in_data [2];
   logic [7:0]  tx_data [2];
   logic [11:0] cw_out  [2];

   int errors = 0;
   int checks = 0;

   // instance 0 has no terminator, instance 1 appends CR LF
   hamming_ascii_tx #(.TERM(1'b0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .tx_full(tx_full[0]), .tx_wr(tx_wr[0]),
      .tx_data(tx_data[0]), .busy(busy[0]), .cw_out(cw_out[0]));

   hamming_ascii_tx #(.TERM(1'b1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .tx_full(tx_full[1]), .tx_wr(tx_wr[1]),
      .tx_data(tx_data[1]), .busy(busy[1]), .cw_out(cw_out[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Generic Hamming: data fills non-power-of-two positions in order; parity at 2^j covers positions with bit j set
   function automatic logic [11:0] model_cw(input logic [7:0] d);
      logic [12:0] pos;
      int di;
      pos = '0;
      di  = 0;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            pos[p] = d[di];
            di++;
         end
      end
      for (int j = 1; j <= 8; j = j * 2) begin
         logic par;
         par = 1'b0;
         for (int p = 1; p <= 12; p++)
            if ((p & j) != 0 && p != j) par ^= pos[p];
         pos[j] = par;
      end
      return pos[12:1];
   endfunction

   // Caller has already driven in_valid/in_data for instance k.
   // mode: 0 no backpressure, 1 five-cycle stall at the 3rd char, 2 toggling full, 3 random full
   task automatic run_frame(input int k, input logic [7:0] d, input int mode,
                            input logic hold, input logic [7:0] nd);
      logic [11:0] cw;
      logic [7:0]  exp_q[$];
      logic [7:0]  got_q[$];
      int          c, stall, wr_full;
      bit          done;
      cw = model_cw(d);
      for (int i = 11; i >= 0; i--) exp_q.push_back(cw[i] ? 8'h31 : 8'h30);
      if (k == 1) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
      c = 0;
      while (!in_ready[k] && c < 50) begin
         @(negedge clk);
         c++;
      end
      check("accept_wait", {31'd0, in_ready[k]}, 32'd1);
      @(posedge clk) #1;
      in_valid[k] = hold;
      in_data[k]  = nd;
      c = 0; stall = 0; wr_full = 0; done = 0;
      while (!done && c < 200) begin
         case (mode)
            1: begin
               if (got_q.size() == 2 && stall < 5) begin
                  tx_full[k] = 1'b1;
                  stall++;
               end else tx_full[k] = 1'b0;
            end
            2: tx_full[k] = c[0];
            3: tx_full[k] = ($urandom_range(0, 3) == 0);
            default: tx_full[k] = 1'b0;
         endcase
         @(negedge clk);
         if (tx_wr[k]) got_q.push_back(tx_data[k]);
         if (tx_wr[k] && tx_full[k]) wr_full++;
         if (mode == 0 && c == 0) check("first_wr_latency", {31'd0, tx_wr[k]}, 32'd1);
         if (!busy[k]) done = 1;
         else begin
            @(posedge clk) #1;
            c++;
         end
      end
      tx_full[k] = 1'b0;
      check("frame_timeout", {31'd0, done}, 32'd1);
      check("wr_while_full", wr_full, 0);
      check("in_ready_after", {31'd0, in_ready[k]}, 32'd1);
      check("cw_out", {20'd0, cw_out[k]}, {20'd0, cw});
      check("n_writes", got_q.size(), exp_q.size());
      if (mode == 0) check("write_cycles", c, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("char%0d_d%02h", i, d), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
   endtask

   initial begin
      int n5;
      reset = 1'b1;
      in_valid = '0;
      tx_full  = '0;
      in_data[0] = 8'h00;
      in_data[1] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready[1]}, 32'd0);
      check("rst_busy", {31'd0, busy[1]}, 32'd0);
      check("rst_tx_wr", {31'd0, tx_wr[1]}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data[1]}, 32'd0);
      check("rst_cw_out", {20'd0, cw_out[1]}, 32'd0);
      @(posedge clk) #1;
      reset = 1'b0;

      in_valid[1] = 1'b1; in_data[1] = 8'hFF;
      run_frame(1, 8'hFF, 0, 1'b0, 8'h00);
      check("cw_ff_literal", {20'd0, cw_out[1]}, {20'd0, 12'b111101110111});

      in_valid[0] = 1'b1; in_data[0] = 8'h01;
      run_frame(0, 8'h01, 0, 1'b0, 8'h00);
      check("cw_01_literal", {20'd0, cw_out[0]}, {20'd0, 12'b000000000111});

      in_valid[1] = 1'b1; in_data[1] = 8'h00;
      run_frame(1, 8'h00, 0, 1'b0, 8'h00);

      in_valid[1] = 1'b1; in_data[1] = 8'hA5;
      run_frame(1, 8'hA5, 1, 1'b0, 8'h00);

      in_valid[1] = 1'b1; in_data[1] = 8'h3C;
      run_frame(1, 8'h3C, 0, 1'b1, 8'hC3);
      run_frame(1, 8'hC3, 0, 1'b0, 8'h00);

      // reset while the 6th character is on the bus
      @(posedge clk) #1;
      in_valid[1] = 1'b1; in_data[1] = 8'h5A;
      @(posedge clk) #1;
      in_valid[1] = 1'b0;
      n5 = 0;
      for (int i = 0; i < 20 && n5 < 5; i++) begin
         @(negedge clk);
         if (tx_wr[1]) n5++;
      end
      check("pre_reset_writes", n5, 5);
      @(posedge clk) #1;
      reset = 1'b1;
      #1;
      check("midrst_tx_wr", {31'd0, tx_wr[1]}, 32'd0);
      check("midrst_busy", {31'd0, busy[1]}, 32'd0);
      check("midrst_cw_out", {20'd0, cw_out[1]}, 32'd0);
      @(posedge clk) #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'd0, in_ready[1]}, 32'd1);
      check("post_rst_busy", {31'd0, busy[1]}, 32'd0);
      in_valid[1] = 1'b1; in_data[1] = 8'h96;
      run_frame(1, 8'h96, 0, 1'b0, 8'h00);

      for (int t = 0; t < 24; t++) begin
         int          k;
         logic [7:0]  d;
         k = $urandom_range(0, 1);
         d = 8'($urandom);
         @(posedge clk) #1;
         in_valid[k] = 1'b1;
         in_data[k]  = d;
         run_frame(k, d, $urandom_range(0, 3), 1'b0, 8'h00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
